// File: rtl/int_mul_seq.sv
// -----------------------------------------------------------------------------
// int_mul_seq
//
// Sequential 56x56 unsigned multiplier using the shift-and-add method.
// Operands are captured with a valid/ready handshake. A three-state machine
// (IDLE, CALC, DONE) then processes one multiplier bit per clock, LSB first,
// into a 112-bit accumulator. The result is presented with a second
// valid/ready handshake.
//
// The latency is always 56 cycles from the accepting edge to the first cycle
// of out_valid, whatever the operand values are. A new operation can be
// accepted one cycle after a result is handed off, so back-to-back throughput
// is one result every 58 cycles.
//
// Configuration macro:
//   INT_MUL_SAT_EN - when defined, y saturates to all ones if the product
//                    does not fit in 56 bits. When undefined, y is the low
//                    56 bits of the product (wrap-around). ovf is identical
//                    in both builds.
//
// Ports:
//   clk        in   1   clock; all state changes on the rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   operands a/b are valid
//   in_ready   out  1   block can accept operands (IDLE only)
//   a          in  56   unsigned multiplicand
//   b          in  56   unsigned multiplier
//   out_valid  out  1   result valid (DONE only)
//   out_ready  in   1   consumer accepts the result
//   y          out 56   product, low 56 bits or saturated
//   ovf        out  1   product bits [111:56] are nonzero
// -----------------------------------------------------------------------------
module int_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [55:0] a,
    input  logic [55:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [55:0] y,
    output logic        ovf
);

    // State encoding, kept as plain constants so older tools can use them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0]  LAST_BIT = 6'd55;
    localparam logic [55:0] SAT_VAL  = 56'hFF_FFFF_FFFF_FFFF;

    logic [1:0]   r_state;
    logic [1:0]   w_stateNext;

    logic [55:0]  r_a;
    logic [55:0]  r_b;
    logic [111:0] r_acc;
    logic [5:0]   r_cnt;
    logic [55:0]  r_y;
    logic         r_ovf;

    logic         w_bit;
    logic         w_lastBit;
    logic [111:0] w_partial;
    logic [111:0] w_accNext;
    logic         w_ovfNext;
    logic [55:0]  w_yNext;

    // Shift-and-add datapath. The multiplicand is zero-extended to the full
    // accumulator width before it is shifted, so bits shifted past position
    // 55 are kept and the 112-bit sum never drops a carry.
    always_comb begin
        w_bit     = r_b[r_cnt];
        w_lastBit = (r_cnt == LAST_BIT);
        w_partial = {56'd0, r_a} << r_cnt;
        w_accNext = w_bit ? (r_acc + w_partial) : r_acc;
    end

    // Result formatting for the value latched on entry to DONE. It is taken
    // from w_accNext so that the contribution of bit 55 is included.
    always_comb begin
        w_ovfNext = |w_accNext[111:56];
`ifdef INT_MUL_SAT_EN
        w_yNext   = w_ovfNext ? SAT_VAL : w_accNext[55:0];
`else
        w_yNext   = w_accNext[55:0];
`endif
    end

    // Next-state logic. CALC has no early exit, which keeps the latency fixed
    // for zero operands too. DONE waits for the consumer. An accepted result
    // always passes through IDLE before new operands are taken, so a new
    // operation never starts on the handoff edge.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_stateNext = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_lastBit) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State register. Reset has priority over every handshake input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Operand capture, accumulation and result registers. The operands are
    // copied on acceptance, so changes on a/b during CALC or DONE have no
    // effect. y/ovf are loaded only on the CALC->DONE transition and cleared
    // on the handoff, so they read zero in IDLE and CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_y   <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_accNext;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_lastBit) begin
                        r_y   <= w_yNext;
                        r_ovf <= w_ovfNext;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_y   <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_y   <= '0;
                    r_ovf <= 1'b0;
                end
            endcase
        end
    end

    // Handshake flags are decoded directly from the state register, so both
    // are glitch-free and change only on clock edges.
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        y         = r_y;
        ovf       = r_ovf;
    end

endmodule

// File: tb/tb_int_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_int_mul_seq
//
// Self-checking bench for int_mul_seq. Expected products come from plain
// 112-bit arithmetic on the operands. Latency, handshake and reset behaviour
// are checked as directed steps. Random operands exercise the datapath.
// -----------------------------------------------------------------------------
module tb_int_mul_seq;

    localparam logic [55:0] ALL_ONES = 56'hFF_FFFF_FFFF_FFFF;
    localparam int          LATENCY  = 56;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] a;
    logic [55:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [55:0] y;
    logic        ovf;

    int assertCount = 0;
    int failCount   = 0;

    int_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backstop so that the run always ends, even if the stimulus stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock. Samples and drives happen 1 ns after the rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [55:0] obs,
                               input logic [55:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Random 56-bit operand. It is sometimes shortened so that small
    // products and non-overflowing cases also appear.
    function automatic logic [55:0] rand56();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        t = t >> $urandom_range(0, 40);
        return t[55:0];
    endfunction

    // One complete operation. The expected result is computed from the
    // operands with full-width arithmetic. The operation holds DONE for
    // holdCycles with out_ready low and then hands off with in_valid
    // asserted, which must not start a new operation. When injectBusy is set,
    // in_valid with a=7, b=9 is driven during CALC and must be ignored.
    task automatic applyStimulus(input logic [55:0] opA, input logic [55:0] opB,
                                 input int holdCycles, input bit injectBusy);
        logic [111:0] full;
        logic         expOvf;
        logic [55:0]  expY;
        full   = {56'd0, opA} * {56'd0, opB};
        expOvf = (full >> 56) != 112'd0;
`ifdef INT_MUL_SAT_EN
        expY   = expOvf ? ALL_ONES : full[55:0];
`else
        expY   = full[55:0];
`endif
        checkOutput("idle_in_ready", 56'(in_ready), 56'd1);
        a         = opA;
        b         = opB;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        stepCycle();
        in_valid = 1'b0;
        a        = rand56();
        b        = rand56();
        checkOutput("calc_in_ready", 56'(in_ready), 56'd0);
        checkOutput("calc_y_zero", y, 56'd0);
        for (int k = 1; k <= LATENCY; k++) begin
            if (injectBusy && k == 10) begin
                in_valid = 1'b1;
                a        = 56'd7;
                b        = 56'd9;
            end else begin
                in_valid = 1'b0;
            end
            stepCycle();
            if (k == LATENCY - 1) begin
                checkOutput("early_out_valid", 56'(out_valid), 56'd0);
                checkOutput("calc_ovf_zero", 56'(ovf), 56'd0);
            end
        end
        checkOutput("done_out_valid", 56'(out_valid), 56'd1);
        checkOutput("done_y", y, expY);
        checkOutput("done_ovf", 56'(ovf), 56'(expOvf));
        for (int h = 0; h < holdCycles; h++) begin
            in_valid = 1'b1;
            stepCycle();
            checkOutput("hold_y", y, expY);
            checkOutput("hold_ovf", 56'(ovf), 56'(expOvf));
            checkOutput("hold_in_ready", 56'(in_ready), 56'd0);
            checkOutput("hold_out_valid", 56'(out_valid), 56'd1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = rand56();
        b         = rand56();
        stepCycle();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("handoff_out_valid", 56'(out_valid), 56'd0);
        checkOutput("handoff_in_ready", 56'(in_ready), 56'd1);
        checkOutput("handoff_y_zero", y, 56'd0);
        checkOutput("handoff_ovf_zero", 56'(ovf), 56'd0);
    endtask

    initial begin
        bit sawValid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        checkOutput("reset_in_ready", 56'(in_ready), 56'd1);
        checkOutput("reset_out_valid", 56'(out_valid), 56'd0);
        checkOutput("reset_y", y, 56'd0);
        checkOutput("reset_ovf", 56'(ovf), 56'd0);

        // Directed operations: small product, overflow, zero operand,
        // held result, and in_valid ignored during CALC.
        applyStimulus(56'd3, 56'd5, 0, 1'b0);
        applyStimulus(ALL_ONES, 56'd2, 0, 1'b0);
        applyStimulus(56'd0, ALL_ONES, 0, 1'b0);
        applyStimulus(56'd1000, 56'd1000, 10, 1'b0);
        applyStimulus(56'd6, 56'd4, 0, 1'b1);
        applyStimulus(ALL_ONES, ALL_ONES, 1, 1'b0);

        // Random operations.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(rand56(), rand56(), i % 3, 1'(i % 2));
        end

        // Reset at cycle 20 of CALC aborts the operation.
        a        = 56'd12345;
        b        = 56'd678;
        in_valid = 1'b1;
        stepCycle();
        in_valid = 1'b0;
        repeat (19) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("calc_rst_in_ready", 56'(in_ready), 56'd1);
        checkOutput("calc_rst_out_valid", 56'(out_valid), 56'd0);
        checkOutput("calc_rst_y", y, 56'd0);
        sawValid = 1'b0;
        for (int k = 0; k < LATENCY + 4; k++) begin
            stepCycle();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("calc_rst_no_pulse", 56'(sawValid), 56'd0);

        // Reset in DONE takes priority over out_ready.
        a        = 56'd99;
        b        = 56'd77;
        in_valid = 1'b1;
        stepCycle();
        in_valid = 1'b0;
        repeat (LATENCY) stepCycle();
        checkOutput("pre_rst_out_valid", 56'(out_valid), 56'd1);
        checkOutput("pre_rst_y", y, 56'd7623);
        rst       = 1'b1;
        out_ready = 1'b1;
        stepCycle();
        rst       = 1'b0;
        out_ready = 1'b0;
        checkOutput("done_rst_out_valid", 56'(out_valid), 56'd0);
        checkOutput("done_rst_y", y, 56'd0);
        checkOutput("done_rst_in_ready", 56'(in_ready), 56'd1);

        // Reset in IDLE takes priority over in_valid.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 56'd5;
        b        = 56'd5;
        stepCycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("idle_rst_in_ready", 56'(in_ready), 56'd1);
        stepCycle();
        checkOutput("idle_rst_not_accepted", 56'(in_ready), 56'd1);

        // One more operation to confirm normal operation after reset.
        applyStimulus(56'd123456789, 56'd987654321, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/int_mul_seq.md
INT_MUL_SEQ -- requirements
Module: int_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: operands a/b are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-005 SHALL have port a, input, 56 bits: unsigned multiplicand.
REQ-006 SHALL have port b, input, 56 bits: unsigned multiplier.
REQ-007 SHALL have port out_valid, output, 1 bit: result valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-009 SHALL have port y, output, 56 bits: product, low 56 bits or saturated per REQ-026.
REQ-010 SHALL have port ovf, output, 1 bit: high when the full 112-bit product has a nonzero value in bits [111:56].

Function
REQ-011 SHALL implement a state machine with exactly three states: IDLE, CALC, DONE.
REQ-012 SHALL drive in_ready high only in IDLE; out_valid high only in DONE.
REQ-013 In IDLE, in_valid=1 at a rising edge SHALL register a and b, clear the 112-bit accumulator and the 6-bit bit counter, and enter CALC.
REQ-014 In CALC, each cycle SHALL examine one multiplier bit, LSB first: if set, add the multiplicand (shifted left by the counter value) into the accumulator; then increment the counter.
REQ-015 Accumulator additions SHALL be 112-bit unsigned with no lost carries; the full product SHALL equal a*b exactly.
REQ-016 After the counter reaches 55 and that bit is processed, SHALL enter DONE; out_valid SHALL first be high exactly 56 cycles after the accepting edge.
REQ-017 Latency SHALL be fixed at 56 cycles regardless of operand values; zero operands get no early exit.
REQ-018 In DONE, y and ovf SHALL hold stable while out_ready=0; out_valid=1 with out_ready=1 at an edge SHALL return the block to IDLE.
REQ-019 in_valid SHALL be ignored in CALC and DONE; a/b changes after acceptance SHALL NOT affect the result.
REQ-020 A new operation SHALL NOT be accepted on the same edge that delivers a result; in_ready rises the cycle after the handoff (back-to-back throughput: one result per 58 cycles).
REQ-021 y and ovf SHALL be registered outputs, updated only on entry to DONE; they read 0 in IDLE and CALC.

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE, clear accumulator, counter and operand registers, and set y=0, ovf=0, out_valid=0, in_ready=1 on the next cycle.
REQ-023 rst SHALL take priority over every other input, including in_valid in IDLE and out_ready in DONE.
REQ-024 Reset during CALC or DONE SHALL abort the operation; no out_valid pulse SHALL follow for it.

Configuration
REQ-025 Macro INT_MUL_SAT_EN SHALL select overflow handling; ovf behaves identically in both builds.
REQ-026 With INT_MUL_SAT_EN defined, y SHALL be 56'hFF_FFFF_FFFF_FFFF when ovf=1, otherwise product[55:0].
REQ-027 Without INT_MUL_SAT_EN, y SHALL always be product[55:0] (wrap-around truncation).

Verification
REQ-028 a=3, b=5, in_valid pulse, out_ready=1 -> out_valid high 56 cycles after acceptance for one cycle, y=15, ovf=0.
REQ-029 a=56'hFF_FFFF_FFFF_FFFF, b=2 -> ovf=1; y=56'hFF_FFFF_FFFF_FFFE without macro, y=56'hFF_FFFF_FFFF_FFFF with INT_MUL_SAT_EN.
REQ-030 a=0, b=56'hFF_FFFF_FFFF_FFFF -> still 56-cycle latency, y=0, ovf=0.
REQ-031 a=1000, b=1000, out_ready=0 for 10 cycles after out_valid -> y=1000000 held stable, in_ready=0 throughout, then IDLE one cycle after out_ready=1.
REQ-032 In CALC, in_valid with a=7, b=9 -> ignored, first result (e.g. 6*4=24) delivered unchanged; rst at cycle 20 of CALC -> IDLE, y=0, no out_valid.
